spi_peripheral: RTL

SPI mode-0 (CPOL=0, CPHA=0) peripheral that forms the far end of our SPI master link. It oversamples SCLK, SS_N and MOSI in the clk48 domain and shifts in MSB-first WIDTH-bit words, presenting each one as a single-cycle pulse. Concurrently it shifts out a byte supplied by local logic through a one-entry valid/ready transmit buffer on MISO. It sits on the GPIO pins opposite the master and feeds local command/register logic.

---
 rtl/spi_peripheral.sv | 123 ++++++++++++
 1 files changed

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 peripheral, oversampled in clk48, with a one-entry transmit buffer
module spi_peripheral #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk48,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0] sclk_sq, ss_sq, mosi_sq;
  logic sclk_hq, ss_hq;
  logic [CW-1:0] bit_cnt_q;
  logic [WIDTH-1:0] rx_shift_q, tx_shift_q, buf_q, rx_data_q;
  logic rx_valid_q, miso_q, miso_oe_q, busy_q, tx_ready_q, tx_underrun_q;
  logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic load, wr, last;
  logic [WIDTH-1:0] load_d, rx_d, tx_d;
  assign sclk_s = sclk_sq[SYNC_STAGES-1];
  assign ss_s = ss_sq[SYNC_STAGES-1];
  assign mosi_s = mosi_sq[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hq;
  assign sclk_fall = ~sclk_s & sclk_hq;
  assign ss_rise = ss_s & ~ss_hq;
  assign ss_fall = ~ss_s & ss_hq;
  assign wr = tx_valid & tx_ready_q;
  assign last = bit_cnt_q == CW'(WIDTH - 1);
  assign load_d = tx_ready_q ? '0 : buf_q;
  assign rx_d = {rx_shift_q[WIDTH-2:0], mosi_s};
  assign tx_d = (bit_cnt_q == '0) ? load_d : tx_shift_q << 1;
  // A load happens at frame start and at each word boundary on a falling SCLK edge, unless ss_n rises first
  assign load = (state_q == IDLE) ? ss_fall : (~ss_rise & sclk_fall & (bit_cnt_q == '0));
  // Synchronize the asynchronous pins and keep one history flop for edge detection
  always_ff @(posedge clk48) begin
    if (rst) begin
      sclk_sq <= '0;
      ss_sq <= '1;
      mosi_sq <= '0;
      sclk_hq <= 1'b0;
      ss_hq <= 1'b1;
    end else begin
      sclk_sq <= {sclk_sq[SYNC_STAGES-2:0], sclk};
      ss_sq <= {ss_sq[SYNC_STAGES-2:0], ss_n};
      mosi_sq <= {mosi_sq[SYNC_STAGES-2:0], mosi};
      sclk_hq <= sclk_s;
      ss_hq <= ss_s;
    end
  end
  // Transmit buffer: a write fills it, a load empties it; a write in a load cycle waits for the next word
  always_ff @(posedge clk48) begin
    if (rst) begin
      buf_q <= '0;
      tx_ready_q <= 1'b1;
      tx_underrun_q <= 1'b0;
    end else begin
      buf_q <= wr ? tx_data : buf_q;
      tx_ready_q <= wr ? 1'b0 : (load ? 1'b1 : tx_ready_q);
      tx_underrun_q <= load & tx_ready_q;
    end
  end
  // Frame state machine; ss_n rising takes priority over any coincident SCLK edge
  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      miso_q <= 1'b0;
      miso_oe_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (ss_fall) begin
          state_q <= ACTIVE;
          bit_cnt_q <= '0;
          miso_oe_q <= 1'b1;
          busy_q <= 1'b1;
          tx_shift_q <= load_d;
          miso_q <= load_d[WIDTH-1];
        end
      end else if (ss_rise) begin
        state_q <= IDLE;
        bit_cnt_q <= '0;
        miso_oe_q <= 1'b0;
        miso_q <= 1'b0;
        busy_q <= 1'b0;
      end else if (sclk_rise) begin
        rx_shift_q <= rx_d;
        bit_cnt_q <= last ? '0 : bit_cnt_q + 1'b1;
        if (last) begin
          rx_data_q <= rx_d;
          rx_valid_q <= 1'b1;
        end
      end else if (sclk_fall) begin
        tx_shift_q <= tx_d;
        miso_q <= tx_d[WIDTH-1];
      end
    end
  end
  assign miso = miso_q;
  assign miso_oe = miso_oe_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign busy = busy_q;
endmodule
